// File: rtl/fft_16.sv
// 16-point radix-2 DIT FFT, fully pipelined: one transform per clock, 4-edge latency.
// Optional macro FFT_STAGE_SCALE_EN halves every butterfly output (overall 1/16).

module fft_16_bfly #(
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 14,
    parameter int M       = 0
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    output logic signed [DATA_W-1:0] p_re,
    output logic signed [DATA_W-1:0] p_im,
    output logic signed [DATA_W-1:0] q_re,
    output logic signed [DATA_W-1:0] q_im
);
    function automatic real tw_cos(input int m);
        case (m)
            0:       return 1.0;
            1:       return 0.9238795325112867;
            2:       return 0.7071067811865476;
            3:       return 0.3826834323650898;
            4:       return 0.0;
            5:       return -0.3826834323650898;
            6:       return -0.7071067811865476;
            7:       return -0.9238795325112867;
            default: return 1.0;
        endcase
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    logic signed [DATA_W-1:0] w_re, w_im;

    generate
        if (M == 0) begin : g_w0
            assign w_re = b_re;
            assign w_im = b_im;
        end else if (M == 4) begin : g_w4
            // multiply by -j: swap and negate, no rounding
            assign w_re = b_im;
            assign w_im = -b_re;
        end else begin : g_mul
            localparam int WW = 2 * DATA_W;
            localparam int MS = (M > 4) ? M - 4 : 4 - M;
            localparam logic signed [DATA_W-1:0] C_RE = DATA_W'(rnd(tw_cos(M) * (2.0 ** TW_FRAC)));
            localparam logic signed [DATA_W-1:0] C_IM = DATA_W'(-rnd(tw_cos(MS) * (2.0 ** TW_FRAC)));
            logic signed [WW-1:0] p_rr, p_ii, p_ri, p_ir;
            logic signed [WW:0]   t_re, t_im;
            assign p_rr = WW'(b_re) * WW'(C_RE);
            assign p_ii = WW'(b_im) * WW'(C_IM);
            assign p_ri = WW'(b_re) * WW'(C_IM);
            assign p_ir = WW'(b_im) * WW'(C_RE);
            assign t_re = (WW+1)'(p_rr) - (WW+1)'(p_ii);
            assign t_im = (WW+1)'(p_ri) + (WW+1)'(p_ir);
            assign w_re = DATA_W'(t_re >>> TW_FRAC);
            assign w_im = DATA_W'(t_im >>> TW_FRAC);
        end
    endgenerate

`ifdef FFT_STAGE_SCALE_EN
    // one guard bit so the halved result never wraps
    logic signed [DATA_W:0] s_re, s_im, d_re, d_im;
    assign s_re = (DATA_W+1)'(a_re) + (DATA_W+1)'(w_re);
    assign s_im = (DATA_W+1)'(a_im) + (DATA_W+1)'(w_im);
    assign d_re = (DATA_W+1)'(a_re) - (DATA_W+1)'(w_re);
    assign d_im = (DATA_W+1)'(a_im) - (DATA_W+1)'(w_im);
    assign p_re = DATA_W'(s_re >>> 1);
    assign p_im = DATA_W'(s_im >>> 1);
    assign q_re = DATA_W'(d_re >>> 1);
    assign q_im = DATA_W'(d_im >>> 1);
`else
    assign p_re = a_re + w_re;
    assign p_im = a_im + w_im;
    assign q_re = a_re - w_re;
    assign q_im = a_im - w_im;
`endif
endmodule

module fft_16 #(
    parameter int DATA_W  = 16,
    parameter int TW_FRAC = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic signed [DATA_W-1:0] X0_Real, X1_Real, X2_Real, X3_Real, X4_Real, X5_Real,
                                     X6_Real, X7_Real, X8_Real, X9_Real, X10_Real, X11_Real,
                                     X12_Real, X13_Real, X14_Real, X15_Real,
    input  logic signed [DATA_W-1:0] X0_Im, X1_Im, X2_Im, X3_Im, X4_Im, X5_Im, X6_Im, X7_Im,
                                     X8_Im, X9_Im, X10_Im, X11_Im, X12_Im, X13_Im, X14_Im, X15_Im,
    output logic signed [DATA_W-1:0] O_X0_Real, O_X1_Real, O_X2_Real, O_X3_Real, O_X4_Real,
                                     O_X5_Real, O_X6_Real, O_X7_Real, O_X8_Real, O_X9_Real,
                                     O_X10_Real, O_X11_Real, O_X12_Real, O_X13_Real,
                                     O_X14_Real, O_X15_Real,
    output logic signed [DATA_W-1:0] O_X0_Im, O_X1_Im, O_X2_Im, O_X3_Im, O_X4_Im, O_X5_Im,
                                     O_X6_Im, O_X7_Im, O_X8_Im, O_X9_Im, O_X10_Im, O_X11_Im,
                                     O_X12_Im, O_X13_Im, O_X14_Im, O_X15_Im
);
    localparam int N = 16;

    logic [N-1:0][DATA_W-1:0]    in_re, in_im, brv_re, brv_im;
    logic [3:0][N-1:0][DATA_W-1:0] sin_re, sin_im, bf_re, bf_im, stg_re, stg_im;

    assign in_re = {X15_Real, X14_Real, X13_Real, X12_Real, X11_Real, X10_Real, X9_Real, X8_Real,
                    X7_Real, X6_Real, X5_Real, X4_Real, X3_Real, X2_Real, X1_Real, X0_Real};
    assign in_im = {X15_Im, X14_Im, X13_Im, X12_Im, X11_Im, X10_Im, X9_Im, X8_Im,
                    X7_Im, X6_Im, X5_Im, X4_Im, X3_Im, X2_Im, X1_Im, X0_Im};

    generate
        for (genvar i = 0; i < N; i++) begin : g_brv
            localparam int R = ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
            assign brv_re[i] = in_re[R];
            assign brv_im[i] = in_im[R];
        end
    endgenerate

    // stage s reads the register of stage s-1; stage 0 reads the reordered inputs
    assign sin_re = {stg_re[2:0], brv_re};
    assign sin_im = {stg_im[2:0], brv_im};

    generate
        for (genvar s = 0; s < 4; s++) begin : g_stg
            for (genvar b = 0; b < N / 2; b++) begin : g_bf
                localparam int H  = 1 << s;
                localparam int J  = b % H;
                localparam int I0 = (b / H) * 2 * H + J;
                fft_16_bfly #(.DATA_W(DATA_W), .TW_FRAC(TW_FRAC), .M(J << (3 - s))) u_bf (
                    .a_re(sin_re[s][I0]),     .a_im(sin_im[s][I0]),
                    .b_re(sin_re[s][I0 + H]), .b_im(sin_im[s][I0 + H]),
                    .p_re(bf_re[s][I0]),      .p_im(bf_im[s][I0]),
                    .q_re(bf_re[s][I0 + H]),  .q_im(bf_im[s][I0 + H])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_re <= '0;
            stg_im <= '0;
        end else begin
            stg_re <= bf_re;
            stg_im <= bf_im;
        end
    end

    assign {O_X15_Real, O_X14_Real, O_X13_Real, O_X12_Real, O_X11_Real, O_X10_Real, O_X9_Real,
            O_X8_Real, O_X7_Real, O_X6_Real, O_X5_Real, O_X4_Real, O_X3_Real, O_X2_Real,
            O_X1_Real, O_X0_Real} = stg_re[3];
    assign {O_X15_Im, O_X14_Im, O_X13_Im, O_X12_Im, O_X11_Im, O_X10_Im, O_X9_Im, O_X8_Im,
            O_X7_Im, O_X6_Im, O_X5_Im, O_X4_Im, O_X3_Im, O_X2_Im, O_X1_Im, O_X0_Im} = stg_im[3];
endmodule

// File: tb/tb_fft_16.sv
// Random-stream bench for fft_16 against an array-based DFT model, plus directed
// impulse / DC / two-sample vectors and mid-stream resets.

module tb_fft_16;
    localparam int  TWF  = 14;
    localparam int  MSK  = 2047;
    localparam real PI   = 3.14159265358979323846;

    logic clk, rst_n;
    logic signed [15:0] x_re [16];
    logic signed [15:0] x_im [16];
    logic signed [15:0] o_re [16];
    logic signed [15:0] o_im [16];

    int e_re [2048][16];
    int e_im [2048][16];
    int t, rst_at, nchk, nmis;

    fft_16 #(.DATA_W(16), .TW_FRAC(TWF)) dut (
        .clk(clk), .rst_n(rst_n),
        .X0_Real(x_re[0]),   .X0_Im(x_im[0]),   .O_X0_Real(o_re[0]),   .O_X0_Im(o_im[0]),
        .X1_Real(x_re[1]),   .X1_Im(x_im[1]),   .O_X1_Real(o_re[1]),   .O_X1_Im(o_im[1]),
        .X2_Real(x_re[2]),   .X2_Im(x_im[2]),   .O_X2_Real(o_re[2]),   .O_X2_Im(o_im[2]),
        .X3_Real(x_re[3]),   .X3_Im(x_im[3]),   .O_X3_Real(o_re[3]),   .O_X3_Im(o_im[3]),
        .X4_Real(x_re[4]),   .X4_Im(x_im[4]),   .O_X4_Real(o_re[4]),   .O_X4_Im(o_im[4]),
        .X5_Real(x_re[5]),   .X5_Im(x_im[5]),   .O_X5_Real(o_re[5]),   .O_X5_Im(o_im[5]),
        .X6_Real(x_re[6]),   .X6_Im(x_im[6]),   .O_X6_Real(o_re[6]),   .O_X6_Im(o_im[6]),
        .X7_Real(x_re[7]),   .X7_Im(x_im[7]),   .O_X7_Real(o_re[7]),   .O_X7_Im(o_im[7]),
        .X8_Real(x_re[8]),   .X8_Im(x_im[8]),   .O_X8_Real(o_re[8]),   .O_X8_Im(o_im[8]),
        .X9_Real(x_re[9]),   .X9_Im(x_im[9]),   .O_X9_Real(o_re[9]),   .O_X9_Im(o_im[9]),
        .X10_Real(x_re[10]), .X10_Im(x_im[10]), .O_X10_Real(o_re[10]), .O_X10_Im(o_im[10]),
        .X11_Real(x_re[11]), .X11_Im(x_im[11]), .O_X11_Real(o_re[11]), .O_X11_Im(o_im[11]),
        .X12_Real(x_re[12]), .X12_Im(x_im[12]), .O_X12_Real(o_re[12]), .O_X12_Im(o_im[12]),
        .X13_Real(x_re[13]), .X13_Im(x_im[13]), .O_X13_Real(o_re[13]), .O_X13_Im(o_im[13]),
        .X14_Real(x_re[14]), .X14_Im(x_im[14]), .O_X14_Real(o_re[14]), .O_X14_Im(o_im[14]),
        .X15_Real(x_re[15]), .X15_Im(x_im[15]), .O_X15_Real(o_re[15]), .O_X15_Im(o_im[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input integer got, input integer exp);
        nchk++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap16(input longint v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    function automatic int rev4(input int i);
        return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
    endfunction

    function automatic int bf(input int a, input int b);
`ifdef FFT_STAGE_SCALE_EN
        return (a + b) >>> 1;
`else
        return wrap16(longint'(a + b));
`endif
    endfunction

    // Spec-level transform of the currently driven vector into slot idx
    task automatic model(input int idx);
        int ar[16], ai[16];
        int h, m, wr, wi, br, bi, a0r, a0i;
        for (int i = 0; i < 16; i++) begin
            ar[i] = x_re[rev4(i)];
            ai[i] = x_im[rev4(i)];
        end
        for (int s = 0; s < 4; s++) begin
            h = 1 << s;
            for (int i = 0; i < 16; i++) begin
                if ((i & h) == 0) begin
                    m  = (i % h) * (8 / h);
                    wr = int'($cos(2.0 * PI * m / 16.0) * (2.0 ** TWF));
                    wi = -int'($sin(2.0 * PI * m / 16.0) * (2.0 ** TWF));
                    if (m == 0) begin
                        br = ar[i + h]; bi = ai[i + h];
                    end else if (m == 4) begin
                        br = ai[i + h]; bi = wrap16(-longint'(ar[i + h]));
                    end else begin
                        br = wrap16((longint'(ar[i + h]) * wr - longint'(ai[i + h]) * wi) >>> TWF);
                        bi = wrap16((longint'(ar[i + h]) * wi + longint'(ai[i + h]) * wr) >>> TWF);
                    end
                    a0r = ar[i]; a0i = ai[i];
                    ar[i] = bf(a0r, br);      ai[i] = bf(a0i, bi);
                    ar[i + h] = bf(a0r, -br); ai[i + h] = bf(a0i, -bi);
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            e_re[idx][k] = ar[k];
            e_im[idx][k] = ai[k];
        end
    endtask

    // One clock: sample, scribble inputs mid-cycle, then check outputs on the falling edge
    task automatic cyc(input logic r);
        integer er, ei;
        rst_n = r;
        @(posedge clk);
        t++;
        if (!r) rst_at = t;
        model(t & MSK);
        #1;
        for (int k = 0; k < 16; k++) begin
            x_re[k] = 16'($urandom);
            x_im[k] = 16'($urandom);
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            er = (t - 3 > rst_at) ? e_re[(t - 3) & MSK][k] : 0;
            ei = (t - 3 > rst_at) ? e_im[(t - 3) & MSK][k] : 0;
            chk($sformatf("bin%0d_re@%0d", k, t), o_re[k], er);
            chk($sformatf("bin%0d_im@%0d", k, t), o_im[k], ei);
        end
    endtask

    task automatic set_const(input int v0, input int v1, input int rest);
        for (int k = 0; k < 16; k++) begin
            x_re[k] = 16'(rest);
            x_im[k] = '0;
        end
        x_re[0] = 16'(v0);
        x_re[1] = 16'(v1);
    endtask

    int  imp_v, dc_v;
    real rr, ri;

    initial begin
        t = 0; rst_at = 0; nchk = 0; nmis = 0;
`ifdef FFT_STAGE_SCALE_EN
        imp_v = 16; dc_v = 16;
`else
        imp_v = 256; dc_v = 256;
`endif
        rst_n = 1'b0;
        set_const(0, 0, 0);
        cyc(1'b0);
        cyc(1'b0);

        // random stream, full-range samples, with a single-edge reset and a close second one
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 16; k++) begin
                x_re[k] = (i < 100) ? 16'($signed(12'($urandom))) : 16'($urandom);
                x_im[k] = (i < 100) ? 16'($signed(12'($urandom))) : 16'($urandom);
            end
            cyc((i == 150 || i == 152) ? 1'b0 : 1'b1);
        end

        // impulse then DC on consecutive edges
        set_const(256, 0, 0);
        cyc(1'b1);
        set_const(16, 16, 16);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("imp_re%0d", k), o_re[k], imp_v);
            chk($sformatf("imp_im%0d", k), o_im[k], 0);
        end
        cyc(1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("dc_re%0d", k), o_re[k], (k == 0) ? dc_v : 0);
            chk($sformatf("dc_im%0d", k), o_im[k], 0);
        end

        // two-sample vector
        set_const(256, 512, 0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
`ifndef FFT_STAGE_SCALE_EN
        chk("two_x0_re", o_re[0], 768);    chk("two_x0_im", o_im[0], 0);
        chk("two_x4_re", o_re[4], 256);    chk("two_x4_im", o_im[4], -512);
        chk("two_x8_re", o_re[8], -256);   chk("two_x8_im", o_im[8], 0);
        chk("two_x12_re", o_re[12], 256);  chk("two_x12_im", o_im[12], 512);
        for (int k = 0; k < 16; k++) begin
            rr = 256.0 + 512.0 * $cos(2.0 * PI * k / 16.0) - real'(o_re[k]);
            ri = -512.0 * $sin(2.0 * PI * k / 16.0) - real'(o_im[k]);
            chk($sformatf("two_tol_re%0d", k), (rr <= 1.0 && rr >= -1.0) ? 1 : 0, 1);
            chk($sformatf("two_tol_im%0d", k), (ri <= 1.0 && ri >= -1.0) ? 1 : 0, 1);
        end
`endif
        cyc(1'b1);
        cyc(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nmis);
        $finish;
    end
endmodule
